cook_timer_ctrl: RTL and testbench

COOK_TIMER_CTRL -- requirements
Module: cook_timer_ctrl

---
 rtl/cook_timer_pkg.sv | 17 +
 rtl/cook_timer_ctrl_time_lut.sv | 37 +++
 rtl/cook_timer_ctrl.sv | 127 ++++++++++++
 tb/tb_cook_timer_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/cook_timer_pkg.sv
// rtl/cook_timer_pkg.sv - shared types and widths for the cook timer controller
// Holds the controller state enum and the field widths used by the top level
// and by the time table.
package cook_timer_pkg;

    localparam int TIME_W  = 5;   // time-unit counter width (max table value 21)
    localparam int TYPE_W  = 2;   // program type field
    localparam int LEVEL_W = 3;   // program level field

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_RUN    = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/cook_timer_ctrl_time_lut.sv
// rtl/cook_timer_ctrl_time_lut.sv - combinational program time table
// Ports:
//   TCOUNT  in  TYPE_W   program type
//   PCOUNT  in  LEVEL_W  program level (0..7)
//   TIME    out TIME_W   run length in time units
// Table: type0 always 0; type1 3*P; type2 0,3,4,6,7,9,10,12; type3 0 for P=0
// else P+2.
module time_lut
    import cook_timer_pkg::*;
(
    input  logic [TYPE_W-1:0]  TCOUNT,
    input  logic [LEVEL_W-1:0] PCOUNT,
    output logic [TIME_W-1:0]  TIME
);

    always_comb begin
        TIME = '0;
        case (TCOUNT)
            2'd0: TIME = '0;
            2'd1: TIME = TIME_W'(3 * PCOUNT);
            2'd2: begin
                case (PCOUNT)
                    3'd0: TIME = 5'd0;
                    3'd1: TIME = 5'd3;
                    3'd2: TIME = 5'd4;
                    3'd3: TIME = 5'd6;
                    3'd4: TIME = 5'd7;
                    3'd5: TIME = 5'd9;
                    3'd6: TIME = 5'd10;
                    3'd7: TIME = 5'd12;
                endcase
            end
            2'd3: TIME = (PCOUNT == '0) ? '0 : TIME_W'(PCOUNT) + TIME_W'(2);
        endcase
    end

endmodule

// File: rtl/cook_timer_ctrl.sv
// rtl/cook_timer_ctrl.sv - cook timer controller: table lookup, prescaled countdown, done pulse
// Parameter TICK_DIV (1..256): clock cycles per time unit.
// Optional feature macro: COOK_TIMER_PAUSE_EN adds the PAUSE input.
// Ports:
//   CLK     in   clock, all state on rising edge
//   RST_N   in   asynchronous active-low reset
//   START   in   request a run, only honoured in IDLE
//   TCOUNT  in   program type, latched when START is accepted
//   PCOUNT  in   program level, latched when START is accepted
//   CANCEL  in   abort the current run (wins over tick, PAUSE and START)
//   PAUSE   in   (COOK_TIMER_PAUSE_EN only) freeze the countdown in RUN
//   BUSY    out  high in LOOKUP and RUN
//   DONE    out  one-cycle pulse on normal completion
//   REMAIN  out  registered time units left
module cook_timer_ctrl
    import cook_timer_pkg::*;
#(
    parameter int TICK_DIV = 4
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               START,
    input  logic [TYPE_W-1:0]  TCOUNT,
    input  logic [LEVEL_W-1:0] PCOUNT,
    input  logic               CANCEL,
`ifdef COOK_TIMER_PAUSE_EN
    input  logic               PAUSE,
`endif
    output logic               BUSY,
    output logic               DONE,
    output logic [TIME_W-1:0]  REMAIN
);

    // Fixed 8-bit prescaler covers the whole legal TICK_DIV range, including 1.
    localparam int           PRE_W   = 8;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

    state_t               state_q, state_d;
    logic [TYPE_W-1:0]    tcount_q, tcount_d;
    logic [LEVEL_W-1:0]   pcount_q, pcount_d;
    logic [TIME_W-1:0]    remain_q, remain_d;
    logic [PRE_W-1:0]     pre_q, pre_d;
    logic [TIME_W-1:0]    lut_time;

    time_lut u_time_lut (
        .TCOUNT (tcount_q),
        .PCOUNT (pcount_q),
        .TIME   (lut_time)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= ST_IDLE;
            tcount_q <= '0;
            pcount_q <= '0;
            remain_q <= '0;
            pre_q    <= '0;
        end else begin
            state_q  <= state_d;
            tcount_q <= tcount_d;
            pcount_q <= pcount_d;
            remain_q <= remain_d;
            pre_q    <= pre_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tcount_d = tcount_q;
        pcount_d = pcount_q;
        remain_d = remain_q;
        pre_d    = pre_q;

        case (state_q)
            ST_IDLE: begin
                if (START && !CANCEL) begin
                    tcount_d = TCOUNT;
                    pcount_d = PCOUNT;
                    state_d  = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                pre_d = '0;
                if (CANCEL) begin
                    remain_d = '0;
                    state_d  = ST_IDLE;
                end else begin
                    remain_d = lut_time;
                    state_d  = (lut_time == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (CANCEL) begin
                    remain_d = '0;
                    pre_d    = '0;
                    state_d  = ST_IDLE;
                end
`ifdef COOK_TIMER_PAUSE_EN
                else if (PAUSE) begin
                    // hold prescaler and REMAIN exactly where they are
                end
`endif
                else if (pre_q == PRE_MAX) begin
                    pre_d = '0;
                    // saturating decrement: the last unit lands on 0 and ends the run
                    if (remain_q <= TIME_W'(1)) begin
                        remain_d = '0;
                        state_d  = ST_DONE;
                    end else begin
                        remain_d = remain_q - TIME_W'(1);
                    end
                end else begin
                    pre_d = pre_q + PRE_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign BUSY   = (state_q == ST_LOOKUP) || (state_q == ST_RUN);
    assign DONE   = (state_q == ST_DONE);
    assign REMAIN = remain_q;

endmodule

// File: tb/tb_cook_timer_ctrl.sv
// tb/tb_cook_timer_ctrl.sv - self-checking bench for cook_timer_ctrl
module tb_cook_timer_ctrl;
    import cook_timer_pkg::*;

    localparam int TD = 4;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       START = 1'b0;
    logic       CANCEL = 1'b0;
    logic [1:0] TCOUNT = '0;
    logic [2:0] PCOUNT = '0;
    logic       BUSY;
    logic       DONE;
    logic [4:0] REMAIN;
`ifdef COOK_TIMER_PAUSE_EN
    logic       PAUSE = 1'b0;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    cook_timer_ctrl #(.TICK_DIV(TD)) dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .START  (START),
        .TCOUNT (TCOUNT),
        .PCOUNT (PCOUNT),
        .CANCEL (CANCEL),
`ifdef COOK_TIMER_PAUSE_EN
        .PAUSE  (PAUSE),
`endif
        .BUSY   (BUSY),
        .DONE   (DONE),
        .REMAIN (REMAIN)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int t;
        int p;
        int exp_t;
        int cancel_at;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input int cyc, input logic [6:0] act, input logic [6:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got busy/done/remain=%b/%b/%0d expected %b/%b/%0d",
                      name, cyc, act[6], act[5], act[4:0], exp[6], exp[5], exp[4:0]);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Run length straight from the program rules.
    function automatic int time_model(input int t, input int p);
        case (t)
            0: return 0;
            1: return 3 * p;
            2: return (p == 0) ? 0 : 3 * ((p + 1) / 2) + ((p % 2 == 0) ? 1 : 0);
            default: return (p == 0) ? 0 : p + 2;
        endcase
    endfunction

    // Start a run in cycle 0 and compare every following cycle against the
    // expected timeline; stray STARTs are thrown in at cycles 5, 20 and in the
    // DONE cycle, all of which must be ignored.
    task automatic run_check(input int t, input int p, input int exp_t, input int cancel_at, input string name);
        int end_c;
        int last;
        bit cancelled;
        logic [6:0] e;
        end_c = 2 + TD * exp_t;
        cancelled = (cancel_at >= 1) && (cancel_at < end_c);
        last = cancelled ? cancel_at + 2 : end_c + 2;
        TCOUNT = 2'(t);
        PCOUNT = 3'(p);
        START  = 1'b1;
        for (int c = 1; c <= last; c++) begin
            @(posedge CLK);
            #1;
            START  = 1'b0;
            CANCEL = 1'b0;
            if (cancelled && c > cancel_at)  e = '0;
            else if (c == 1)                 e = {1'b1, 1'b0, 5'd0};
            else if (c < end_c)              e = {1'b1, 1'b0, 5'(exp_t - (c - 2) / TD)};
            else if (c == end_c)             e = {1'b0, 1'b1, 5'd0};
            else                             e = '0;
            check(name, c, {BUSY, DONE, REMAIN}, e);
            if (cancelled && c == cancel_at) CANCEL = 1'b1;
            if ((c == 5 || c == 20 || c == end_c) && c <= end_c && (!cancelled || c <= cancel_at)) begin
                START  = 1'b1;
                TCOUNT = 2'($urandom);
                PCOUNT = 3'($urandom);
            end
        end
        START  = 1'b0;
        CANCEL = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int t;
        int p;
        int tt;
        int ca;
        int found;
        int done_cyc;

        vecs[0] = '{1, 7, 21, -1};
        vecs[1] = '{3, 0, 0, -1};
        vecs[2] = '{2, 3, 6, 10};
        vecs[3] = '{0, 5, 0, -1};
        vecs[4] = '{2, 7, 12, -1};
        vecs[5] = '{3, 7, 9, -1};
        vecs[6] = '{1, 0, 0, -1};
        vecs[7] = '{2, 1, 3, 1};
        vecs[8] = '{3, 1, 3, -1};
        vecs[9] = '{1, 1, 3, 13};

        #2;
        check("reset_state", 0, {BUSY, DONE, REMAIN}, '0);
        repeat (2) @(posedge CLK);
        #1;
        check("reset_held", 0, {BUSY, DONE, REMAIN}, '0);
        @(negedge CLK);
        RST_N = 1'b1;

        foreach (vecs[i])
            run_check(vecs[i].t, vecs[i].p, vecs[i].exp_t, vecs[i].cancel_at, $sformatf("vec%0d", i));

        for (int i = 0; i < 12; i++) begin
            t  = int'($urandom_range(0, 3));
            p  = int'($urandom_range(0, 7));
            tt = time_model(t, p);
            ca = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 1 + TD * tt)) : -1;
            run_check(t, p, tt, ca, $sformatf("rand%0d_t%0d_p%0d", i, t, p));
        end

        // Asynchronous reset in the middle of a run.
        TCOUNT = 2'd1;
        PCOUNT = 3'd7;
        START  = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        found = 0;
        for (int c = 0; c < 200 && found == 0; c++) begin
            @(posedge CLK);
            #1;
            if (REMAIN == 5'd4) found = 1;
        end
        check_int("reach_remain4", found, 1);
        #2;
        RST_N = 1'b0;
        #1;
        check("async_reset", 0, {BUSY, DONE, REMAIN}, '0);
        @(negedge CLK);
        RST_N = 1'b1;
        run_check(2, 3, 6, -1, "after_reset");

`ifdef COOK_TIMER_PAUSE_EN
        TCOUNT = 2'd1;
        PCOUNT = 3'd1;
        START  = 1'b1;
        done_cyc = -1;
        for (int c = 1; c <= 30; c++) begin
            @(posedge CLK);
            #1;
            START = 1'b0;
            if (DONE && done_cyc < 0) done_cyc = c;
            if (c == 14) check("pause_busy", c, {BUSY, DONE, REMAIN}, {1'b1, 1'b0, 5'd3});
            PAUSE = (c >= 5 && c < 15);
        end
        PAUSE = 1'b0;
        check_int("pause_done_cycle", done_cyc, 24);
`else
        done_cyc = 0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
